// File: rtl/logic_op_if.sv
// Handshake and data bundle for logic_op_unit: input beat channel
// (in_valid/in_ready with operator, mode and operands) and result channel
// (out_valid/out_ready with Z, its reduction flags and the beat count).
interface logic_op_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             mode;
  logic             last;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             z_and;
  logic             z_or;
  logic             z_xor;
  logic [CNT_W-1:0] beats;

  // Producer/consumer side: drives beats, accepts results.
  modport master (
    output in_valid, op, mode, last, A, B, out_ready,
    input  in_ready, out_valid, Z, z_and, z_or, z_xor, beats
  );

  // The logic unit itself.
  modport slave (
    input  in_valid, op, mode, last, A, B, out_ready,
    output in_ready, out_valid, Z, z_and, z_or, z_xor, beats
  );
endinterface

// File: rtl/logic_op_unit.sv
// Registered bitwise logic unit. Single-shot beats produce one result each;
// accumulate bursts fold every beat's A through the operator latched on the
// first beat and produce one result on the last beat. Results sit in an
// output register guarded by a valid/ready handshake.
module logic_op_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst,
  logic_op_if.slave  bus
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic             load_out;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op_sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    case (op_sel)
      3'd0:    apply_op = x & y;
      3'd1:    apply_op = ~(x & y);
      3'd2:    apply_op = x | y;
      3'd3:    apply_op = ~(x | y);
      3'd4:    apply_op = x ^ y;
      3'd5:    apply_op = ~(x ^ y);
      3'd6:    apply_op = ~x;
      default: apply_op = x;
    endcase
  endfunction

  // A new result may load whenever the output register is empty or draining.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Fold step and saturating beat counter for the accumulate path.
  assign acc_next = apply_op(op_q, acc_q, bus.A);
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Next-state decode for the burst FSM and the output register.
  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    beats_d  = beats_q;
    load_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.mode || bus.last) begin
            z_d      = apply_op(bus.op, bus.A, bus.B);
            beats_d  = CNT_W'(1);
            load_out = 1'b1;
          end else begin
            acc_d   = apply_op(bus.op, bus.A, bus.B);
            op_d    = bus.op;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (bus.last) begin
            z_d      = acc_next;
            beats_d  = cnt_inc;
            load_out = 1'b1;
            state_d  = IDLE;
          end else begin
            acc_d = acc_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh result keeps out_valid high even while the old one transfers.
    out_valid_d = load_out || (out_valid_q && !bus.out_ready);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      z_q         <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Z         = z_q;
  assign bus.beats     = beats_q;
  assign bus.z_and     = &z_q;
  assign bus.z_or      = |z_q;
  assign bus.z_xor     = ^z_q;

endmodule

// File: tb/tb_logic_op_unit.sv
// Scoreboard bench for logic_op_unit. Two instances (CNT_W=8 and CNT_W=4)
// receive identical stimulus; expected results are queued when a beat is
// accepted and a monitor pops and compares on every output transfer.
module tb_logic_op_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] op = '0;
  logic       mode = 1'b0;
  logic       last = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_ready = 1'b1;

  bit         rand_ready = 1'b0;
  bit         ready_force = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_op_if #(.WIDTH(8), .CNT_W(8)) if0 ();
  logic_op_if #(.WIDTH(8), .CNT_W(4)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.op        = op;
  assign if0.mode      = mode;
  assign if0.last      = last;
  assign if0.A         = a;
  assign if0.B         = b;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.op        = op;
  assign if1.mode      = mode;
  assign if1.last      = last;
  assign if1.A         = a;
  assign if1.B         = b;
  assign if1.out_ready = out_ready;

  logic_op_unit #(.WIDTH(8), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  logic_op_unit #(.WIDTH(8), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] z;
    int         n;
  } exp_t;

  exp_t       exp_q[$];
  bit         burst_open = 1'b0;
  logic [2:0] burst_op;
  logic [7:0] burst_a0;
  logic [7:0] burst_b0;
  logic [7:0] burst_rest[$];

  function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return ~(x & y);
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  // Record an accepted beat; a result is queued when an operation completes.
  task automatic model_beat(input logic [2:0] o, input logic m, input logic l,
                            input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [7:0] r;
    if (!burst_open) begin
      if (!m || l) begin
        e.z = ref_f(o, x, y);
        e.n = 1;
        exp_q.push_back(e);
      end else begin
        burst_open = 1'b1;
        burst_op   = o;
        burst_a0   = x;
        burst_b0   = y;
        burst_rest.delete();
      end
    end else begin
      burst_rest.push_back(x);
      if (l) begin
        r = ref_f(burst_op, burst_a0, burst_b0);
        foreach (burst_rest[i]) r = ref_f(burst_op, r, burst_rest[i]);
        e.z = r;
        e.n = 1 + burst_rest.size();
        exp_q.push_back(e);
        burst_open = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issue one beat (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic send(input logic [2:0] o, input logic m, input logic l,
                      input logic [7:0] x, input logic [7:0] y);
    int waited;
    op = o; mode = m; last = l; a = x; b = y;
    in_valid = 1'b1;
    waited = 0;
    #2;
    while (!if0.in_ready && waited < 200) begin
      @(posedge clk); #3;
      waited++;
    end
    if (!if0.in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      model_beat(o, m, l, x, y);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Downstream ready: forced value or random, updated at posedge+2.
  initial begin
    forever begin
      @(posedge clk); #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: a transfer is due at the next edge when valid && ready.
  initial begin
    exp_t e;
    int   n0, n1;
    forever begin
      @(posedge clk); #3;
      if (!rst && if0.out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          n0 = (e.n > 255) ? 255 : e.n;
          n1 = (e.n > 15) ? 15 : e.n;
          check("z",      32'(if0.Z), 32'(e.z));
          check("beats8", 32'(if0.beats), 32'(n0));
          check("z_and",  32'(if0.z_and), 32'(e.z == 8'hFF));
          check("z_or",   32'(if0.z_or), 32'(e.z != 8'h00));
          check("z_xor",  32'(if0.z_xor), 32'($countones(e.z) % 2));
          check("valid4", 32'(if1.out_valid), 32'd1);
          check("z4",     32'(if1.Z), 32'(e.z));
          check("beats4", 32'(if1.beats), 32'(n1));
        end
      end
    end
  end

  logic [7:0] sweep_a;
  logic [7:0] sweep_b;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rst_valid", 32'(if0.out_valid), 32'd0);
    check("rst_z",     32'(if0.Z), 32'd0);
    check("rst_beats", 32'(if0.beats), 32'd0);
    check("rst_flags", {29'd0, if0.z_and, if0.z_or, if0.z_xor}, 32'd0);
    check("rst_ready", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1;

    // Single-shot sweep, back to back.
    sweep_a = 8'hF0;
    sweep_b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b0, 1'b0, sweep_a, sweep_b);
      check("sweep_latency", 32'(if0.out_valid), 32'd1);
    end

    // XOR burst; op/mode/B on later beats must be ignored.
    send(3'd4, 1'b1, 1'b0, 8'h01, 8'h02);
    check("burst_no_out1", 32'(if0.out_valid), 32'd0);
    send(3'd0, 1'b0, 1'b0, 8'h04, 8'hAA);
    check("burst_no_out2", 32'(if0.out_valid), 32'd0);
    send(3'd2, 1'b1, 1'b1, 8'h08, 8'h55);
    check("burst_out", 32'(if0.out_valid), 32'd1);

    // Operator latched on first beat.
    send(3'd0, 1'b1, 1'b0, 8'hFF, 8'h0F);
    send(3'd4, 1'b0, 1'b1, 8'h3C, 8'h00);
    drain();

    // Backpressure: result held, input blocked.
    ready_force = 1'b0;
    @(posedge clk); #1;
    send(3'd2, 1'b0, 1'b0, 8'h55, 8'h0A);
    #2;
    check("bp_in_ready", 32'(if0.in_ready), 32'd0);
    repeat (5) @(posedge clk);
    #3;
    check("bp_hold_z",     32'(if0.Z), 32'h5F);
    check("bp_hold_valid", 32'(if0.out_valid), 32'd1);
    @(posedge clk); #1;
    ready_force = 1'b1;

    // Random beats with random downstream readiness.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom));
    end
    send(3'($urandom_range(0, 7)), 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    rand_ready = 1'b0;
    drain();

    // Reset in the middle of an AND burst discards it.
    send(3'd0, 1'b1, 1'b0, 8'hF3, 8'h7E);
    send(3'd0, 1'b1, 1'b0, 8'h1C, 8'h00);
    rst = 1'b1;
    burst_open = 1'b0;
    burst_rest.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check("midrst_valid", 32'(if0.out_valid), 32'd0);
    check("midrst_beats", 32'(if0.beats), 32'd0);
    @(posedge clk); #1;
    send(3'd2, 1'b0, 1'b0, 8'h01, 8'h80);
    drain();

    // 20-beat OR burst: the 4-bit counter saturates at F.
    send(3'd2, 1'b1, 1'b0, 8'h01, 8'h00);
    for (int i = 0; i < 18; i++) send(3'd0, 1'b1, 1'b0, 8'h01, 8'($urandom));
    send(3'd0, 1'b1, 1'b1, 8'h01, 8'h00);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
